whack_scorer: RTL and testbench

Reader end of the mole bus. Samples the 16 mole lines driven by the mole generator and the raw player switches, and turns switch toggles into hit/miss events. Keeps a saturating score and a seconds-based game timer. Its outputs drive the mole-clear request and the score/countdown path toward the seven-segment display chain.

---
 rtl/whack_pkg.sv | 9 +
 rtl/popcount16.sv | 10 +
 rtl/whack_scorer.sv | 84 ++++++++
 tb/tb_whack_scorer.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/whack_pkg.sv
// whack_pkg: state encoding and parameter defaults shared by the whack scorer slice.
package whack_pkg;
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_OVER = 2'b10;
  localparam int NUM_MOLES_D    = 16;
  localparam int GAME_SECONDS_D = 30;
  localparam int MAX_SCORE_D    = 9999;
endpackage

// File: rtl/popcount16.sv
// popcount16: combinational population count of a 16-bit vector.
module popcount16 (
  input  logic [15:0] data,
  output logic [4:0]  count
);
  always_comb begin
    count = '0;
    for (int i = 0; i < 16; i++) count = count + 5'(data[i]);
  end
endmodule

// File: rtl/whack_scorer.sv
// whack_scorer: synchronises player switches, classifies toggles against the mole
// pattern as hits/misses, and keeps a saturating score and a seconds countdown.
module whack_scorer
  import whack_pkg::*;
#(
  parameter int NUM_MOLES    = NUM_MOLES_D,
  parameter int GAME_SECONDS = GAME_SECONDS_D,
  parameter int MAX_SCORE    = MAX_SCORE_D
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic [NUM_MOLES-1:0] moles_i,
  input  logic [NUM_MOLES-1:0] switches_i,
  input  logic                 start_i,
  input  logic                 tick_i,
  output logic                 whacked_o,
  output logic [NUM_MOLES-1:0] whack_mask_o,
  output logic                 miss_o,
  output logic [13:0]          score_o,
  output logic [6:0]           time_left_o,
  output logic                 in_game_o,
  output logic                 game_over_o
);
  localparam logic signed [15:0] MAX_S  = 16'(MAX_SCORE);
  localparam logic [6:0]         GAME_T = 7'(GAME_SECONDS);
  logic [NUM_MOLES-1:0] s1, s2, prev, toggle, hits, misses;
  logic [4:0] nh, nm;
  logic [1:0] state;
  logic run;
  logic signed [15:0] sum;
  logic [13:0] score_next;
  assign toggle = s2 ^ prev;
  assign hits   = toggle & moles_i;
  assign misses = toggle & ~moles_i;
  assign run    = state == ST_RUN;
  assign in_game_o   = run;
  assign game_over_o = state == ST_OVER;
  popcount16 u_hit_count  (.data(hits),   .count(nh));
  popcount16 u_miss_count (.data(misses), .count(nm));
  // Signed 16-bit so a miss-heavy cycle can go below zero before clamping.
  assign sum        = 16'(score_o) + 16'(nh) - 16'(nm);
  assign score_next = sum < 16'sd0 ? 14'd0 : sum > MAX_S ? MAX_S[13:0] : sum[13:0];
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      s1   <= '0;
      s2   <= '0;
      prev <= '0;
    end else begin
      s1   <= switches_i;
      s2   <= s1;
      prev <= s2;
    end
  end
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      whacked_o    <= 1'b0;
      miss_o       <= 1'b0;
      whack_mask_o <= '0;
    end else begin
      whacked_o    <= run && |hits;
      miss_o       <= run && |misses;
      whack_mask_o <= run ? hits : '0;
    end
  end
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state       <= ST_IDLE;
      score_o     <= '0;
      time_left_o <= GAME_T;
    end else if (run) begin
      if (|toggle) score_o <= score_next;
      if (tick_i) begin
        time_left_o <= time_left_o - 7'd1;
        if (time_left_o == 7'd1) state <= ST_OVER;
      end
    end else if (start_i) begin
      state       <= ST_RUN;
      score_o     <= '0;
      time_left_o <= GAME_T;
    end else if (state == ST_IDLE) begin
      time_left_o <= GAME_T;
    end
  end
endmodule

// File: tb/tb_whack_scorer.sv
// tb_whack_scorer: directed checks of reset, scoring, clamping, timer end and restart.
module tb_whack_scorer;
  logic        clock_i = 1'b0;
  logic        reset_i = 1'b0;
  logic [15:0] moles_i = '0;
  logic [15:0] switches_i = '0;
  logic        start_i = 1'b0;
  logic        tick_i = 1'b0;
  logic        whacked_o, miss_o, in_game_o, game_over_o;
  logic [15:0] whack_mask_o;
  logic [13:0] score_o;
  logic [6:0]  time_left_o;
  int n_chk = 0;
  int n_fail = 0;

  whack_scorer dut (
    .clock_i(clock_i), .reset_i(reset_i), .moles_i(moles_i), .switches_i(switches_i),
    .start_i(start_i), .tick_i(tick_i), .whacked_o(whacked_o), .whack_mask_o(whack_mask_o),
    .miss_o(miss_o), .score_o(score_o), .time_left_o(time_left_o),
    .in_game_o(in_game_o), .game_over_o(game_over_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock_i);
      @(negedge clock_i);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    moles_i    = 16'($urandom);
    switches_i = 16'($urandom);
    cyc(2);
    chk("rst_score", 32'(score_o), 0);
    chk("rst_time", 32'(time_left_o), 30);
    chk("rst_in_game", 32'(in_game_o), 0);
    chk("rst_over", 32'(game_over_o), 0);
    chk("rst_whacked", 32'(whacked_o), 0);
    chk("rst_miss", 32'(miss_o), 0);
    chk("rst_mask", 32'(whack_mask_o), 0);
    reset_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      chk("idle_whacked", 32'(whacked_o), 0);
      chk("idle_miss", 32'(miss_o), 0);
      chk("idle_score", 32'(score_o), 0);
      chk("idle_in_game", 32'(in_game_o), 0);
      chk("idle_time", 32'(time_left_o), 30);
    end
    // Single hit
    start_i = 1'b1;
    cyc(1);
    start_i = 1'b0;
    chk("start_in_game", 32'(in_game_o), 1);
    chk("start_time", 32'(time_left_o), 30);
    moles_i = 16'h0010;
    switches_i ^= 16'h0010;
    cyc(2);
    chk("hit_early", 32'(whacked_o), 0);
    cyc(1);
    chk("hit_whacked", 32'(whacked_o), 1);
    chk("hit_mask", 32'(whack_mask_o), 32'h0010);
    chk("hit_miss", 32'(miss_o), 0);
    chk("hit_score", 32'(score_o), 1);
    cyc(1);
    chk("hit_pulse_end", 32'(whacked_o), 0);
    chk("hit_mask_end", 32'(whack_mask_o), 0);
    // Mixed hit/miss then clamp at zero
    switches_i ^= 16'h0010;
    cyc(3);
    chk("score_two", 32'(score_o), 2);
    cyc(1);
    moles_i = 16'h0003;
    switches_i ^= 16'h0083;
    cyc(3);
    chk("mix_whacked", 32'(whacked_o), 1);
    chk("mix_miss", 32'(miss_o), 1);
    chk("mix_mask", 32'(whack_mask_o), 32'h0003);
    chk("mix_score", 32'(score_o), 3);
    cyc(1);
    moles_i = 16'h0000;
    switches_i ^= 16'h0F00;
    cyc(3);
    chk("neg_miss", 32'(miss_o), 1);
    chk("neg_whacked", 32'(whacked_o), 0);
    chk("neg_mask", 32'(whack_mask_o), 0);
    chk("neg_clamp", 32'(score_o), 0);
    cyc(1);
    // Timer end with a whack on the final tick
    tick_i = 1'b1;
    cyc(29);
    tick_i = 1'b0;
    chk("time_one", 32'(time_left_o), 1);
    chk("time_one_run", 32'(in_game_o), 1);
    moles_i = 16'h0010;
    switches_i ^= 16'h0010;
    cyc(2);
    tick_i = 1'b1;
    cyc(1);
    tick_i = 1'b0;
    chk("end_time", 32'(time_left_o), 0);
    chk("end_over", 32'(game_over_o), 1);
    chk("end_in_game", 32'(in_game_o), 0);
    chk("end_whacked", 32'(whacked_o), 1);
    chk("end_score", 32'(score_o), 1);
    switches_i ^= 16'h0011;
    tick_i = 1'b1;
    cyc(3);
    tick_i = 1'b0;
    chk("over_whacked", 32'(whacked_o), 0);
    chk("over_miss", 32'(miss_o), 0);
    chk("over_score", 32'(score_o), 1);
    chk("over_time", 32'(time_left_o), 0);
    // Saturation
    start_i = 1'b1;
    cyc(1);
    start_i = 1'b0;
    chk("restart_score", 32'(score_o), 0);
    chk("restart_time", 32'(time_left_o), 30);
    moles_i = 16'hFFFF;
    for (int i = 0; i < 624; i++) begin
      switches_i = ~switches_i;
      cyc(1);
    end
    switches_i ^= 16'h3FFF;
    cyc(4);
    chk("preload_score", 32'(score_o), 9998);
    switches_i ^= 16'h000F;
    cyc(3);
    chk("sat_score", 32'(score_o), 9999);
    chk("sat_mask", 32'(whack_mask_o), 32'h000F);
    cyc(1);
    switches_i ^= 16'hFFFF;
    cyc(3);
    chk("sat_hold", 32'(score_o), 9999);
    // Restart from OVER, start ignored in RUN, mid-game reset
    tick_i = 1'b1;
    cyc(30);
    tick_i = 1'b0;
    chk("sat_over", 32'(game_over_o), 1);
    chk("sat_frozen", 32'(score_o), 9999);
    start_i = 1'b1;
    cyc(1);
    start_i = 1'b0;
    chk("re_score", 32'(score_o), 0);
    chk("re_time", 32'(time_left_o), 30);
    chk("re_in_game", 32'(in_game_o), 1);
    tick_i = 1'b1;
    cyc(1);
    tick_i = 1'b0;
    start_i = 1'b1;
    cyc(1);
    start_i = 1'b0;
    chk("run_start_ignored", 32'(time_left_o), 29);
    switches_i ^= 16'h0001;
    cyc(3);
    chk("pre_reset_score", 32'(score_o), 1);
    reset_i = 1'b0;
    #2;
    chk("mid_rst_score", 32'(score_o), 0);
    chk("mid_rst_time", 32'(time_left_o), 30);
    chk("mid_rst_in_game", 32'(in_game_o), 0);
    cyc(1);
    reset_i = 1'b1;
    switches_i ^= 16'h0001;
    cyc(4);
    chk("post_rst_score", 32'(score_o), 0);
    chk("post_rst_whacked", 32'(whacked_o), 0);
    chk("post_rst_in_game", 32'(in_game_o), 0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
